stswi_debounce: RTL and testbench



---
 rtl/stswi_debounce.sv | 103 ++++++++++
 tb/tb_stswi_debounce.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/stswi_debounce.sv
// Synchronizes and debounces slide switches, with per-bit rise/fall strobes and an any-change strobe.
// Latency: 2 sync cycles plus STABLE_TICKS prescaler ticks of a stable level; all outputs registered.
// Backpressure: none; strobes are single-cycle and must be sampled when they fire.
module stswi_debounce #(
    parameter int WIDTH        = 3,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] stswi,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_nxt;
    logic             tick;

    logic [CW-1:0]    cnt_q   [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] db_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= stswi;
            sync2 <= sync1;
        end
    end

    // Free-running prescaler shared by all bits; input activity never restarts it.
    always_comb begin
        tick    = (pre_q == PRE_LAST);
        pre_nxt = tick ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_nxt;
        end
    end

    // Any return of sync2 to the accepted level restarts qualification from zero.
    always_comb begin
        mismatch = sync2 ^ sw_db;
        db_nxt   = sw_db;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (!mismatch[i]) begin
                cnt_nxt[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    cnt_nxt[i]  = '0;
                    db_nxt[i]   = sync2[i];
                    rise_nxt[i] = sync2[i];
                    fall_nxt[i] = ~sync2[i];
                end else begin
                    cnt_nxt[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            sw_db   <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            sw_chg  <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_nxt[i];
            end
            sw_db   <= db_nxt;
            sw_rise <= rise_nxt;
            sw_fall <= fall_nxt;
            sw_chg  <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_stswi_debounce.sv
// Directed bench for stswi_debounce: one instance at TICK_DIV=1/STABLE_TICKS=4, one at TICK_DIV=4/STABLE_TICKS=2.
// Expected strobes are queued when stimulus is applied and matched when the DUT strobes.
module tb_stswi_debounce;

    typedef struct {
        int         lo;
        int         hi;
        logic [2:0] db;
        logic [2:0] rise;
        logic [2:0] fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [2:0] in_a, in_b;
    logic [2:0] a_db, a_rise, a_fall;
    logic [2:0] b_db, b_rise, b_fall;
    logic       a_chg, b_chg;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rel_b    = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stswi_debounce #(.WIDTH(3), .TICK_DIV(1), .STABLE_TICKS(4)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_a),
        .stswi   (in_a),
        .sw_db   (a_db),
        .sw_rise (a_rise),
        .sw_fall (a_fall),
        .sw_chg  (a_chg)
    );

    stswi_debounce #(.WIDTH(3), .TICK_DIV(4), .STABLE_TICKS(2)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_b),
        .stswi   (in_b),
        .sw_db   (b_db),
        .sw_rise (b_rise),
        .sw_fall (b_fall),
        .sw_chg  (b_chg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit which, input int lo, input int hi,
                        input logic [2:0] db, input logic [2:0] rise, input logic [2:0] fall);
        exp_t e;
        e.lo = lo; e.hi = hi; e.db = db; e.rise = rise; e.fall = fall;
        if (which) qb.push_back(e);
        else       qa.push_back(e);
    endtask

    // Polls on posedge so it never races the negedge monitors that pop the queues.
    task automatic wait_q(input bit which, input int budget, input string tag);
        int n = 0;
        while (n < budget && (which ? qb.size() : qa.size()) != 0) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, which ? qb.size() : qa.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_a && (a_chg || (|a_rise) || (|a_fall))) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_strobe", 32'({a_rise, a_fall, a_chg}), 0);
            end else begin
                ea = qa.pop_front();
                chk("a_strobe_cycle", cyc, (cyc < ea.lo) ? ea.lo : (cyc > ea.hi) ? ea.hi : cyc);
                chk("a_db_at_strobe", a_db, ea.db);
                chk("a_rise", a_rise, ea.rise);
                chk("a_fall", a_fall, ea.fall);
                chk("a_chg", a_chg, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b && (b_chg || (|b_rise) || (|b_fall))) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_strobe", 32'({b_rise, b_fall, b_chg}), 0);
            end else begin
                eb = qb.pop_front();
                chk("b_strobe_cycle", cyc, (cyc < eb.lo) ? eb.lo : (cyc > eb.hi) ? eb.hi : cyc);
                chk("b_db_at_strobe", b_db, eb.db);
                chk("b_rise", b_rise, eb.rise);
                chk("b_fall", b_fall, eb.fall);
                chk("b_chg", b_chg, 1);
            end
        end
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; in_a = 3'b000; in_b = 3'b000;
        repeat (2) @(negedge clk);
        chk("a_reset_db", a_db, 0);
        chk("a_reset_rise", a_rise, 0);
        chk("a_reset_fall", a_fall, 0);
        chk("a_reset_chg", a_chg, 0);
        chk("b_reset_db", b_db, 0);
        chk("b_reset_chg", b_chg, 0);

        // Clean step on bit 0.
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        in_a = 3'b001;
        push(0, cyc + 6, cyc + 6, 3'b001, 3'b001, 3'b000);
        wait_q(0, 40, "a_step_timeout");
        repeat (3) @(negedge clk);
        chk("a_step_level", a_db, 3'b001);

        // Bit 1 bounces in 2-cycle pulses, then settles high.
        for (int k = 0; k < 4; k++) begin
            in_a = (k % 2 == 0) ? 3'b011 : 3'b001;
            repeat (2) @(negedge clk);
        end
        chk("a_bounce_level", a_db, 3'b001);
        in_a = 3'b011;
        push(0, cyc + 6, cyc + 6, 3'b011, 3'b010, 3'b000);
        wait_q(0, 40, "a_bounce_timeout");

        // Bring all bits high, then drop all three on the same edge.
        in_a = 3'b111;
        push(0, cyc + 6, cyc + 6, 3'b111, 3'b100, 3'b000);
        wait_q(0, 40, "a_allhigh_timeout");
        repeat (2) @(negedge clk);
        in_a = 3'b000;
        push(0, cyc + 6, cyc + 6, 3'b000, 3'b000, 3'b111);
        wait_q(0, 40, "a_multifall_timeout");
        repeat (2) @(negedge clk);
        chk("a_multifall_level", a_db, 3'b000);

        // Reset mid-qualification: outputs clear asynchronously, qualification restarts.
        in_a = 3'b110;
        push(0, cyc + 6, cyc + 6, 3'b110, 3'b110, 3'b000);
        wait_q(0, 40, "a_pre_reset_timeout");
        in_a = 3'b111;
        repeat (3) @(posedge clk);
        #2 rst_a = 1'b0;
        #1;
        chk("a_async_reset_db", a_db, 0);
        chk("a_async_reset_strobes", 32'({a_rise, a_fall, a_chg}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        push(0, cyc + 6, cyc + 6, 3'b111, 3'b111, 3'b000);
        wait_q(0, 40, "a_post_reset_timeout");

        // Switches high through reset qualify as an ordinary rise.
        @(negedge clk);
        in_a  = 3'b101;
        rst_a = 1'b0;
        #1;
        chk("a_powerup_reset_db", a_db, 0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        push(0, cyc + 6, cyc + 6, 3'b101, 3'b101, 3'b000);
        wait_q(0, 40, "a_powerup_timeout");
        repeat (3) @(negedge clk);
        chk("a_powerup_level", a_db, 3'b101);

        // Prescaled instance: tick fires on edges where (cyc - rel_b) % 4 == 0.
        rst_b = 1'b1;
        rel_b = cyc;
        while ((cyc + 5 - rel_b) % 4 != 0) @(negedge clk);
        in_b = 3'b100;
        repeat (6) @(negedge clk);
        in_b = 3'b000;
        repeat (12) @(negedge clk);
        chk("b_glitch_level", b_db, 0);

        in_b = 3'b100;
        push(1, cyc + 7, cyc + 10, 3'b100, 3'b100, 3'b000);
        wait_q(1, 40, "b_rise_timeout");
        repeat (2) @(negedge clk);
        chk("b_rise_level", b_db, 3'b100);
        in_b = 3'b000;
        push(1, cyc + 7, cyc + 10, 3'b000, 3'b000, 3'b100);
        wait_q(1, 40, "b_fall_timeout");

        repeat (10) @(negedge clk);
        chk("a_final_queue", qa.size(), 0);
        chk("b_final_queue", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
